cmos_rgb565_gray: RTL and testbench



---
 rtl/cmos_rgb565_gray.sv | 183 ++++++++++++++++++
 tb/tb_cmos_rgb565_gray.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_rgb565_gray.sv
// cmos_rgb565_gray: assembles the CMOS byte stream into RGB565 pixels plus 8-bit luma,
// with column/row coordinates, a first-pixel marker and malformed-frame detection.
// Build option: define FRAME_SKIP_EN to drop the first SKIP_FRAMES frames after arming.
module cmos_rgb565_gray #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned SKIP_FRAMES = 10
) (
    input  logic        CMOS_oCLK,
    input  logic        iRST_N,
    input  logic        CMOS_VSYNC,
    input  logic        CMOS_HREF,
    input  logic [7:0]  DATA,
    output logic [15:0] pix_rgb,
    output logic [7:0]  pix_gray,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        frame_start,
    output logic        frame_err
);
    localparam int unsigned PW = 10;
    // One spare bit so overlong lines/frames saturate well past the active window
    localparam int unsigned CW = PW + 1;
`ifdef FRAME_SKIP_EN
    localparam int unsigned SKIP_N = SKIP_FRAMES;
`else
    localparam int unsigned SKIP_N = SKIP_FRAMES * 0;
`endif
    localparam int unsigned SW = $clog2(SKIP_N + 2);

    logic          vs_q, vs_d, act_q, act_d, armed_q, armed_d, phase_q, phase_d;
    logic [7:0]    hi_q, hi_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d, y_end;
    logic          err_q, err_d;
    logic [SW-1:0] skip_q, skip_d;
    logic          s1_valid_q, s1_valid_d;
    logic [15:0]   s1_rgb_q, s1_rgb_d;
    logic [PW-1:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;
    logic [15:0]   rgb_q, rgb_d;
    logic [7:0]    gray_q, gray_d;
    logic          valid_q, valid_d, fs_q, fs_d, fe_q, fe_d;
    logic [PW-1:0] px_q, px_d, py_q, py_d;

    logic          line_act, vs_rise, vs_fall, line_end, pix_done, in_win, skip_c;
    logic [7:0]    r8, g8, b8, gray_c;
    logic [15:0]   luma_sum;

    // Luma of the stage-1 pixel: expand to 8 bits per channel, weighted sum, >> 8
    always_comb begin
        r8       = {s1_rgb_q[15:11], s1_rgb_q[15:13]};
        g8       = {s1_rgb_q[10:5],  s1_rgb_q[10:9]};
        b8       = {s1_rgb_q[4:0],   s1_rgb_q[4:2]};
        luma_sum = 16'd77 * 16'(r8) + 16'd150 * 16'(g8) + 16'd29 * 16'(b8);
        gray_c   = 8'(luma_sum >> 8);
    end

    // Next-state: byte pairing, coordinates, frame checking, arming and output stage
    always_comb begin
        vs_d       = CMOS_VSYNC;
        line_act   = CMOS_HREF & ~CMOS_VSYNC;
        act_d      = line_act;
        vs_rise    = ~vs_q & CMOS_VSYNC;
        vs_fall    = vs_q & ~CMOS_VSYNC;
        line_end   = act_q & ~line_act;
        pix_done   = line_act & phase_q;
        in_win     = (x_q < CW'(H_ACTIVE)) && (y_q < CW'(V_ACTIVE));
        skip_c     = (SKIP_N != 0) && (skip_q != SW'(SKIP_N));
        armed_d    = armed_q;
        hi_d       = hi_q;
        x_d        = x_q;
        err_d      = err_q;
        skip_d     = skip_q;
        s1_valid_d = 1'b0;
        s1_rgb_d   = s1_rgb_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        rgb_d      = rgb_q;
        gray_d     = gray_q;
        px_d       = px_q;
        py_d       = py_q;
        valid_d    = s1_valid_q;
        fs_d       = 1'b0;
        fe_d       = 1'b0;

        phase_d = line_act ? ~phase_q : 1'b0;
        if (line_act && !phase_q) hi_d = DATA;

        // Completed pixel: emit only inside the window, otherwise poison the frame
        if (pix_done) begin
            s1_valid_d = armed_q & ~skip_c & in_win;
            s1_rgb_d   = {hi_q, DATA};
            s1_x_d     = PW'(x_q);
            s1_y_d     = PW'(y_q);
            if (!in_win) err_d = 1'b1;
            if (x_q != '1) x_d = x_q + CW'(1);
        end

        // Line end: check width and dangling high byte, advance row if non-empty
        y_end = y_q;
        if (line_end) begin
            x_d = '0;
            if ((x_q != CW'(H_ACTIVE)) || phase_q) err_d = 1'b1;
            if ((x_q != '0) && (y_q != '1)) y_end = y_q + CW'(1);
        end
        y_d = y_end;
        if (CMOS_VSYNC) begin
            x_d = '0;
            y_d = '0;
        end

        // Frame close: report, count skipped frames, then start clean
        if (vs_rise) begin
            fe_d  = armed_q & ~skip_c & (err_d | (y_end != CW'(V_ACTIVE)));
            err_d = 1'b0;
            if (armed_q && skip_c) skip_d = skip_q + SW'(1);
        end
        if (vs_fall) armed_d = 1'b1;

        if (s1_valid_q) begin
            rgb_d  = s1_rgb_q;
            gray_d = gray_c;
            px_d   = s1_x_q;
            py_d   = s1_y_q;
            fs_d   = (s1_x_q == '0) && (s1_y_q == '0);
        end
    end

    // State and output registers
    always_ff @(posedge CMOS_oCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            vs_q       <= 1'b0;
            act_q      <= 1'b0;
            armed_q    <= 1'b0;
            phase_q    <= 1'b0;
            hi_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            err_q      <= 1'b0;
            skip_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_rgb_q   <= '0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            rgb_q      <= '0;
            gray_q     <= '0;
            valid_q    <= 1'b0;
            px_q       <= '0;
            py_q       <= '0;
            fs_q       <= 1'b0;
            fe_q       <= 1'b0;
        end else begin
            vs_q       <= vs_d;
            act_q      <= act_d;
            armed_q    <= armed_d;
            phase_q    <= phase_d;
            hi_q       <= hi_d;
            x_q        <= x_d;
            y_q        <= y_d;
            err_q      <= err_d;
            skip_q     <= skip_d;
            s1_valid_q <= s1_valid_d;
            s1_rgb_q   <= s1_rgb_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            rgb_q      <= rgb_d;
            gray_q     <= gray_d;
            valid_q    <= valid_d;
            px_q       <= px_d;
            py_q       <= py_d;
            fs_q       <= fs_d;
            fe_q       <= fe_d;
        end
    end

    assign pix_rgb     = rgb_q;
    assign pix_gray    = gray_q;
    assign pix_valid   = valid_q;
    assign pix_x       = px_q;
    assign pix_y       = py_q;
    assign frame_start = fs_q;
    assign frame_err   = fe_q;
endmodule

// File: tb/tb_cmos_rgb565_gray.sv
// Directed bench for cmos_rgb565_gray with a 4x2 active window and SKIP_FRAMES=2.
module tb_cmos_rgb565_gray;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        vs    = 1'b0;
    logic        href  = 1'b0;
    logic [7:0]  data  = 8'h00;
    logic [15:0] pix_rgb;
    logic [7:0]  pix_gray;
    logic        pix_valid;
    logic [9:0]  pix_x, pix_y;
    logic        frame_start, frame_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int fe_cnt = 0;
    int fs_cnt = 0;
    logic [15:0] q_rgb[$];
    logic [7:0]  q_gray[$];
    logic [9:0]  q_x[$];
    logic [9:0]  q_y[$];
    logic        q_fs[$];
    int          q_cyc[$];

    cmos_rgb565_gray #(.H_ACTIVE(4), .V_ACTIVE(2), .SKIP_FRAMES(2)) dut (
        .CMOS_oCLK(clk), .iRST_N(rst_n), .CMOS_VSYNC(vs), .CMOS_HREF(href), .DATA(data),
        .pix_rgb(pix_rgb), .pix_gray(pix_gray), .pix_valid(pix_valid),
        .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe and marker, sampled mid-cycle
    always @(negedge clk) begin
        if (pix_valid) begin
            q_rgb.push_back(pix_rgb);
            q_gray.push_back(pix_gray);
            q_x.push_back(pix_x);
            q_y.push_back(pix_y);
            q_fs.push_back(frame_start);
            q_cyc.push_back(cyc);
        end
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (frame_start) fs_cnt <= fs_cnt + 1;
    end

    task automatic drive(input logic v, input logic h, input logic [7:0] d);
        vs = v; href = h; data = d;
        @(posedge clk); #1;
    endtask

    task automatic end_line();
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
    endtask

    // Pixel i of the line carries rgb = {tag, i}
    task automatic send_px_line(input int n, input logic [7:0] tag);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b1, tag);
            drive(1'b0, 1'b1, 8'(i));
        end
        end_line();
    endtask

    task automatic frame_gap();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic good_frame();
        send_px_line(4, 8'hA0);
        send_px_line(4, 8'hA1);
    endtask

    task automatic test_reset();
        int base;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        checks++;
        if ({pix_rgb, pix_gray, pix_valid, pix_x, pix_y, frame_start, frame_err} !== 47'd0) begin
            errors++;
            $display("FAIL reset_outputs got rgb=%h gray=%h v=%b x=%0d y=%0d fs=%b fe=%b want all 0",
                     pix_rgb, pix_gray, pix_valid, pix_x, pix_y, frame_start, frame_err);
        end
        rst_n = 1'b1;
        base = q_rgb.size();
        send_px_line(4, 8'h55);
        send_px_line(4, 8'h56);
        checks++;
        if (q_rgb.size() - base !== 0) begin
            errors++;
            $display("FAIL unarmed_strobes got %0d want 0", q_rgb.size() - base);
        end
    endtask

    task automatic test_colour();
        logic [7:0]  bytes [8];
        logic [15:0] exp_rgb [4];
        logic [7:0]  exp_gray [4];
        int          le [4];
        int          base, fb;
        bytes    = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF};
        exp_rgb  = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};
        exp_gray = '{8'd76, 8'd149, 8'd28, 8'd255};
        fb = fe_cnt;
        frame_gap();
        checks++;
        if (fe_cnt - fb !== 0) begin
            errors++;
            $display("FAIL unarmed_frame_err got %0d want 0", fe_cnt - fb);
        end
        base = q_rgb.size();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, bytes[i]);
            if (i % 2 == 1) le[i / 2] = cyc;
        end
        end_line();
        drive(1'b0, 1'b0, 8'h00);
        checks++;
        if (q_rgb.size() - base !== 4) begin
            errors++;
            $display("FAIL colour_count got %0d want 4", q_rgb.size() - base);
        end
        for (int i = 0; i < 4 && base + i < q_rgb.size(); i++) begin
            checks++;
            if ({q_rgb[base+i], q_gray[base+i], q_x[base+i], q_y[base+i]} !==
                {exp_rgb[i], exp_gray[i], 10'(i), 10'd0}) begin
                errors++;
                $display("FAIL colour_px%0d got rgb=%h gray=%0d x=%0d y=%0d want rgb=%h gray=%0d x=%0d y=0",
                         i, q_rgb[base+i], q_gray[base+i], q_x[base+i], q_y[base+i],
                         exp_rgb[i], exp_gray[i], i);
            end
            checks++;
            if (q_cyc[base+i] !== le[i] + 1) begin
                errors++;
                $display("FAIL colour_latency%0d got edge %0d want edge %0d", i, q_cyc[base+i], le[i] + 1);
            end
        end
    endtask

    task automatic test_frame_markers();
        int base, fb, fsb;
        fb = fe_cnt;
        frame_gap();
        checks++;
        if (fe_cnt - fb !== 1) begin
            errors++;
            $display("FAIL short_frame_err got %0d want 1", fe_cnt - fb);
        end
        base = q_rgb.size();
        fsb  = fs_cnt;
        good_frame();
        fb = fe_cnt;
        frame_gap();
        checks++;
        if (q_rgb.size() - base !== 8) begin
            errors++;
            $display("FAIL frame_count got %0d want 8", q_rgb.size() - base);
        end
        for (int i = 0; i < 8 && base + i < q_rgb.size(); i++) begin
            checks++;
            if ({q_rgb[base+i], q_x[base+i], q_y[base+i], q_fs[base+i]} !==
                {8'hA0 + 8'(i / 4), 8'(i % 4), 10'(i % 4), 10'(i / 4), (i == 0)}) begin
                errors++;
                $display("FAIL frame_px%0d got rgb=%h x=%0d y=%0d fs=%b want x=%0d y=%0d fs=%b",
                         i, q_rgb[base+i], q_x[base+i], q_y[base+i], q_fs[base+i], i % 4, i / 4, i == 0);
            end
        end
        checks++;
        if (fs_cnt - fsb !== 1) begin
            errors++;
            $display("FAIL frame_start_count got %0d want 1", fs_cnt - fsb);
        end
        checks++;
        if (fe_cnt - fb !== 0) begin
            errors++;
            $display("FAIL good_frame_err got %0d want 0", fe_cnt - fb);
        end
    endtask

    task automatic test_odd_bytes();
        logic [7:0]  bytes [7];
        logic [15:0] exp_rgb [7];
        logic [9:0]  exp_x [7];
        int          base, fb;
        bytes   = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h77};
        exp_rgb = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h1200, 16'h1201, 16'h1202, 16'h1203};
        exp_x   = '{10'd0, 10'd1, 10'd2, 10'd0, 10'd1, 10'd2, 10'd3};
        base = q_rgb.size();
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, bytes[i]);
        end_line();
        send_px_line(4, 8'h12);
        fb = fe_cnt;
        frame_gap();
        checks++;
        if (q_rgb.size() - base !== 7) begin
            errors++;
            $display("FAIL odd_count got %0d want 7", q_rgb.size() - base);
        end
        for (int i = 0; i < 7 && base + i < q_rgb.size(); i++) begin
            checks++;
            if ({q_rgb[base+i], q_x[base+i], q_y[base+i]} !== {exp_rgb[i], exp_x[i], (i < 3) ? 10'd0 : 10'd1}) begin
                errors++;
                $display("FAIL odd_px%0d got rgb=%h x=%0d y=%0d want rgb=%h x=%0d",
                         i, q_rgb[base+i], q_x[base+i], q_y[base+i], exp_rgb[i], exp_x[i]);
            end
        end
        checks++;
        if (fe_cnt - fb !== 1) begin
            errors++;
            $display("FAIL odd_frame_err got %0d want 1", fe_cnt - fb);
        end
    endtask

    task automatic test_overlong();
        int base, fb;
        base = q_rgb.size();
        send_px_line(5, 8'h30);
        send_px_line(4, 8'h31);
        fb = fe_cnt;
        frame_gap();
        checks++;
        if (q_rgb.size() - base !== 8) begin
            errors++;
            $display("FAIL overlong_count got %0d want 8", q_rgb.size() - base);
        end
        if (q_rgb.size() - base >= 5) begin
            checks++;
            if ({q_rgb[base+3], q_rgb[base+4], q_y[base+4]} !== {16'h3003, 16'h3100, 10'd1}) begin
                errors++;
                $display("FAIL overlong_edge got %h %h y=%0d want 3003 3100 y=1",
                         q_rgb[base+3], q_rgb[base+4], q_y[base+4]);
            end
        end
        checks++;
        if (fe_cnt - fb !== 1) begin
            errors++;
            $display("FAIL overlong_frame_err got %0d want 1", fe_cnt - fb);
        end
    endtask

    task automatic test_no_partial();
        int base, fb, fsb;
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 8'h11);
        drive(1'b0, 1'b1, 8'h22);
        rst_n = 1'b1;
        base = q_rgb.size();
        fb   = fe_cnt;
        drive(1'b0, 1'b1, 8'h33);
        drive(1'b0, 1'b1, 8'h44);
        drive(1'b0, 1'b1, 8'h55);
        end_line();
        send_px_line(4, 8'h40);
        frame_gap();
        checks++;
        if ({q_rgb.size() - base, fe_cnt - fb} !== {32'd0, 32'd0}) begin
            errors++;
            $display("FAIL partial_frame got strobes=%0d errs=%0d want 0 0", q_rgb.size() - base, fe_cnt - fb);
        end
        base = q_rgb.size();
        fsb  = fs_cnt;
        good_frame();
        fb = fe_cnt;
        frame_gap();
        checks++;
        if (q_rgb.size() - base !== 8 || fs_cnt - fsb !== 1 || fe_cnt - fb !== 0) begin
            errors++;
            $display("FAIL after_partial got strobes=%0d fs=%0d errs=%0d want 8 1 0",
                     q_rgb.size() - base, fs_cnt - fsb, fe_cnt - fb);
        end
    endtask

    task automatic test_reset_mid();
        int base, fb;
        drive(1'b0, 1'b1, 8'h11);
        drive(1'b0, 1'b1, 8'h22);
        drive(1'b0, 1'b1, 8'h33);
        checks++;
        if ({pix_valid, pix_rgb} !== {1'b1, 16'h1122}) begin
            errors++;
            $display("FAIL pre_reset_pixel got v=%b rgb=%h want v=1 rgb=1122", pix_valid, pix_rgb);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({pix_rgb, pix_gray, pix_valid, pix_x, pix_y, frame_start, frame_err} !== 47'd0) begin
            errors++;
            $display("FAIL async_reset got rgb=%h gray=%h v=%b x=%0d y=%0d want all 0",
                     pix_rgb, pix_gray, pix_valid, pix_x, pix_y);
        end
        drive(1'b0, 1'b1, 8'h44);
        rst_n = 1'b1;
        base = q_rgb.size();
        fb   = fe_cnt;
        drive(1'b0, 1'b1, 8'h55);
        drive(1'b0, 1'b1, 8'h66);
        end_line();
        send_px_line(4, 8'h50);
        frame_gap();
        checks++;
        if ({q_rgb.size() - base, fe_cnt - fb} !== {32'd0, 32'd0}) begin
            errors++;
            $display("FAIL post_reset_quiet got strobes=%0d errs=%0d want 0 0", q_rgb.size() - base, fe_cnt - fb);
        end
        base = q_rgb.size();
        good_frame();
        frame_gap();
        checks++;
        if (q_rgb.size() - base !== 8) begin
            errors++;
            $display("FAIL post_reset_frame got %0d want 8", q_rgb.size() - base);
        end
    endtask

    task automatic test_frame_skip();
        int base, fb, fsb;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;
        frame_gap();
        for (int f = 0; f < 3; f++) begin
            base = q_rgb.size();
            fsb  = fs_cnt;
            fb   = fe_cnt;
            good_frame();
            frame_gap();
            checks++;
            if (q_rgb.size() - base !== ((f == 2) ? 8 : 0) || fs_cnt - fsb !== ((f == 2) ? 1 : 0) ||
                fe_cnt - fb !== 0) begin
                errors++;
                $display("FAIL skip_frame%0d got strobes=%0d fs=%0d errs=%0d", f,
                         q_rgb.size() - base, fs_cnt - fsb, fe_cnt - fb);
            end
        end
    endtask

    initial begin
        test_reset();
`ifdef FRAME_SKIP_EN
        test_frame_skip();
`else
        test_colour();
        test_frame_markers();
        test_odd_bytes();
        test_overlong();
        test_no_partial();
        test_reset_mid();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
